// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Holds the fetch PC, issues one word read at a
// time to instruction memory, buffers returned words in a small FIFO and
// presents the head entry to the decoder as opcode/instruction/inst_pc with a
// valid/ready handshake. A redirect loads a new PC, flushes the buffer and
// drops whatever response is still in flight.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req / imem_addr     read request, held with a stable address until ack
//   imem_ack / imem_rdata    single-cycle acknowledge with read data
//   inst_valid / inst_ready  decoder handshake for the FIFO head
//   opcode, instruction      head word split as [6:0] and [31:7]
//   inst_pc                  PC of the head word
//   redirect_valid/_pc       branch/jump target; low two bits are ignored
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [6:0]  opcode,
    output logic [24:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              imem_req_q, imem_req_d;
    logic [31:0]       imem_addr_q, imem_addr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [31:0]       word_mem [FIFO_DEPTH];
    logic [31:0]       pc_mem   [FIFO_DEPTH];

    logic              push;
    logic              pop;
    logic              empty;
    logic [31:0]       target_pc;
    logic [31:0]       head_word;
    logic [31:0]       head_pc;

    // Explicit wrap keeps non-power-of-2 depths (and depth 1) correct.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign target_pc = redirect_pc & ~32'h0000_0003;
    assign empty     = (count_q == '0);
    assign head_word = word_mem[rd_ptr_q];
    assign head_pc   = pc_mem[rd_ptr_q];

    // A redirect hides the head so the decoder never consumes a word that
    // belongs to the abandoned path.
    assign inst_valid  = !empty && !redirect_valid;
    assign pop         = inst_valid && inst_ready;
    assign opcode      = empty ? '0 : head_word[6:0];
    assign instruction = empty ? '0 : head_word[31:7];
    assign inst_pc     = empty ? '0 : head_pc;

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;

    // Fetch control. Requests only launch with a free slot; since the count
    // can only fall while a request is outstanding, every response has room.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        push        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = target_pc;
                end else if (count_q < FULL_CNT) begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    state_d    = IDLE;
                    if (redirect_valid) begin
                        pc_d = target_pc;
                    end else begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end else if (redirect_valid) begin
                    // The request must still complete; FLUSH absorbs its data.
                    pc_d    = target_pc;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (redirect_valid) begin
                    pc_d = target_pc;
                end
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // Buffer pointers; a redirect empties the buffer and overrides any pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the count gates every
    // read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]   <= imem_addr_q;
        end
    end

endmodule
